// File: rtl/prbs_pkg.sv
// Shared PRBS7 (x^7 + x^6 + 1) definitions used by the generator and the checker.
package prbs_pkg;
    localparam int TAP_HI = 6;
    localparam int TAP_LO = 5;
    localparam logic [6:0] PRBS7_SEED = 7'h7F;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_LOST   = 2'd2
    } state_t;

    function automatic logic lfsr_fb(input logic [6:0] s);
        return s[TAP_HI] ^ s[TAP_LO];
    endfunction

    function automatic logic [6:0] lfsr_next(input logic [6:0] s);
        return {s[5:0], lfsr_fb(s)};
    endfunction
endpackage

// File: rtl/prbs7_checker_if.sv
// Stream input and status output bundle of the PRBS7 checker.
interface prbs7_checker_if #(parameter int ERR_W = 16);
    logic             en;
    logic             din;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       state_o;

    modport master (output en, din, clr_cnt,
                    input  locked, err_pulse, err_count, state_o);
    modport slave  (input  en, din, clr_cnt,
                    output locked, err_pulse, err_count, state_o);
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment together yield 1.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= W'(inc);
        else if (inc && (q != {W{1'b1}}))
            q <= q + W'(1);
    end
endmodule

// File: rtl/prbs7_checker.sv
// PRBS7 receive checker: self-syncs in HUNT, free-runs a reference in LOCKED, counts bit errors.
module prbs7_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_COUNT  = 16,
    parameter int LOSS_THRESH = 4,
    parameter int CLEAN_RUN   = 8,
    parameter int ERR_W       = 16
) (
    input logic            clk,
    input logic            rst,
    prbs7_checker_if.slave bus
);
    localparam logic [7:0] LOCK_N  = 8'(LOCK_COUNT);
    localparam logic [7:0] CLEAN_N = 8'(CLEAN_RUN);
    localparam logic [3:0] LOSS_N  = 4'(LOSS_THRESH);

    state_t           state;
    logic [6:0]       sr;
    logic [7:0]       run;
    logic [3:0]       loss;
    logic             lock_q;
    logic             pulse_q;
    logic             pred;
    logic             match;
    logic             cnt_err;
    logic [7:0]       run_inc;
    logic [3:0]       loss_inc;
    logic [ERR_W-1:0] cnt;

    assign pred     = lfsr_fb(sr);
    assign match    = (bus.din == pred);
    assign run_inc  = run + 8'd1;
    assign loss_inc = loss + 4'd1;
    assign cnt_err  = bus.en && (state == ST_LOCKED) && !match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_HUNT;
            sr      <= PRBS7_SEED;
            run     <= '0;
            loss    <= '0;
            lock_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= cnt_err;
            if (bus.en) begin
                case (state)
                    ST_HUNT: begin
                        sr <= {sr[5:0], bus.din};
                        // All-zero register predicts zero forever; never let it build a run.
                        if (match && (sr != 7'd0)) begin
                            if (run_inc == LOCK_N) begin
                                state  <= ST_LOCKED;
                                lock_q <= 1'b1;
                                run    <= '0;
                                loss   <= '0;
                            end else begin
                                run <= run_inc;
                            end
                        end else begin
                            run <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        sr <= lfsr_next(sr);
                        if (!match) begin
                            run  <= '0;
                            loss <= loss_inc;
                            if (loss_inc == LOSS_N) begin
                                state  <= ST_LOST;
                                lock_q <= 1'b0;
                            end
                        end else if (run_inc == CLEAN_N) begin
                            run  <= '0;
                            loss <= '0;
                        end else begin
                            run <= run_inc;
                        end
                    end
                    ST_LOST: begin
                        sr    <= {sr[5:0], bus.din};
                        run   <= '0;
                        loss  <= '0;
                        state <= ST_HUNT;
                    end
                    default: begin
                        state  <= ST_HUNT;
                        lock_q <= 1'b0;
                        run    <= '0;
                        loss   <= '0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.clr_cnt && bus.en),
        .inc (cnt_err),
        .q   (cnt)
    );

    assign bus.locked    = lock_q;
    assign bus.err_pulse = pulse_q;
    assign bus.err_count = cnt;
    assign bus.state_o   = state;
endmodule

// File: tb/tb_prbs7_checker.sv
// Directed bench for prbs7_checker driven by an independent PRBS7 generator.
module tb_prbs7_checker;
    localparam int EW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [6:0] g = 7'h7F;
    int checks = 0;
    int errors = 0;
    int pulses;
    int lock_seen;

    prbs7_checker_if #(.ERR_W(EW)) bus ();

    prbs7_checker #(.ERR_W(EW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input bit inv);
        logic nb;
        nb = g[6] ^ g[5];
        g = {g[5:0], nb};
        bus.din = nb ^ inv;
        bus.en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        bus.en = 1'b0;
        bus.din = 1'($urandom);
        @(posedge clk); #1;
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) send(1'b0);
    endtask

    task automatic reset_pulse();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        g = 7'h7F;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en = 1'b0; bus.din = 1'b0; bus.clr_cnt = 1'b0;
        #3;
        chk("rst_locked", bus.locked, 0);
        chk("rst_pulse", bus.err_pulse, 0);
        chk("rst_count", bus.err_count, 0);
        chk("rst_state", bus.state_o, 0);
        #9 rst = 1'b0;

        // 1: clean stream locks after exactly 16 bits, then stays error-free
        clean(15);
        chk("s1_not_yet", bus.locked, 0);
        clean(1);
        chk("s1_locked", bus.locked, 1);
        chk("s1_state", bus.state_o, 1);
        pulses = 0;
        for (int i = 0; i < 500; i++) begin
            send(1'b0);
            if (bus.err_pulse) pulses++;
        end
        chk("s1_pulses", pulses, 0);
        chk("s1_count", bus.err_count, 0);
        chk("s1_hold", bus.locked, 1);

        // 2: single inverted bit, then 8 clean bits must reset the loss counter
        clean(99);
        send(1'b1);
        chk("s2_pulse", bus.err_pulse, 1);
        chk("s2_count", bus.err_count, 1);
        chk("s2_locked", bus.locked, 1);
        send(1'b0);
        chk("s2_pulse_end", bus.err_pulse, 0);
        clean(7);
        send(1'b1); send(1'b0); send(1'b1); send(1'b0); send(1'b1);
        chk("s2_loss_cleared", bus.locked, 1);
        chk("s2_count3", bus.err_count, 4);
        clean(8);

        // 3: clr_cnt, then four errors spaced two apart force LOST then HUNT
        bus.clr_cnt = 1'b1; send(1'b0); bus.clr_cnt = 1'b0;
        chk("s3_clr", bus.err_count, 0);
        send(1'b1); send(1'b0); send(1'b1); send(1'b0); send(1'b1); send(1'b0);
        chk("s3_still_locked", bus.locked, 1);
        send(1'b1);
        chk("s3_lost_state", bus.state_o, 2);
        chk("s3_lost_locked", bus.locked, 0);
        chk("s3_count", bus.err_count, 4);
        chk("s3_pulse", bus.err_pulse, 1);
        send(1'b0);
        chk("s3_hunt", bus.state_o, 0);
        chk("s3_hunt_pulse", bus.err_pulse, 0);
        clean(15);
        chk("s3_relock_early", bus.locked, 0);
        clean(1);
        chk("s3_relock", bus.locked, 1);
        chk("s3_count_hold", bus.err_count, 4);

        // 4: all-zero input never locks
        reset_pulse();
        lock_seen = 0;
        for (int i = 0; i < 200; i++) begin
            bus.en = 1'b1; bus.din = 1'b0;
            @(posedge clk); #1;
            if (bus.locked) lock_seen++;
        end
        chk("s4_never_lock", lock_seen, 0);
        chk("s4_state", bus.state_o, 0);
        chk("s4_count", bus.err_count, 0);

        // 5: en toggling; idle cycles carry garbage and must change nothing
        reset_pulse();
        for (int i = 0; i < 15; i++) begin send(1'b0); idle(); end
        chk("s5_not_yet", bus.locked, 0);
        send(1'b0);
        chk("s5_locked", bus.locked, 1);
        idle();
        chk("s5_idle_locked", bus.locked, 1);
        for (int i = 0; i < 99; i++) begin send(1'b0); idle(); end
        send(1'b1);
        chk("s5_pulse", bus.err_pulse, 1);
        chk("s5_count", bus.err_count, 1);
        idle();
        chk("s5_pulse_en0", bus.err_pulse, 0);
        chk("s5_count_hold", bus.err_count, 1);
        chk("s5_state_hold", bus.state_o, 1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            send(1'b0); if (bus.err_pulse) pulses++;
            idle();     if (bus.err_pulse) pulses++;
        end
        chk("s5_no_pulses", pulses, 0);
        chk("s5_count_final", bus.err_count, 1);
        chk("s5_locked_final", bus.locked, 1);

        // 6: saturation, clear-with-error, async reset mid-LOCKED
        reset_pulse();
        clean(16);
        chk("s6_locked", bus.locked, 1);
        for (int k = 0; k < 85; k++) begin
            send(1'b1); send(1'b1); send(1'b1);
            clean(8);
        end
        chk("s6_full", bus.err_count, 255);
        chk("s6_full_locked", bus.locked, 1);
        send(1'b1);
        chk("s6_sat", bus.err_count, 255);
        chk("s6_sat_pulse", bus.err_pulse, 1);
        clean(8);
        bus.clr_cnt = 1'b1; send(1'b1); bus.clr_cnt = 1'b0;
        chk("s6_clr_err", bus.err_count, 1);
        chk("s6_clr_pulse", bus.err_pulse, 1);
        clean(2);
        send(1'b1);
        chk("s6_pre_rst", bus.err_count, 2);
        #2 rst = 1'b1;
        #1;
        chk("s6_rst_locked", bus.locked, 0);
        chk("s6_rst_pulse", bus.err_pulse, 0);
        chk("s6_rst_count", bus.err_count, 0);
        chk("s6_rst_state", bus.state_o, 0);
        #2 rst = 1'b0;
        g = 7'h7F;
        clean(15);
        chk("s6_relock_early", bus.locked, 0);
        clean(1);
        chk("s6_relock", bus.locked, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/prbs7_checker.md
Name: prbs7_checker

Overview:
- Receive-side checker for the PRBS7 stream (x^7 + x^6 + 1) produced by the team's LFSR generator, whose flops all reset to 1.
- Self-synchronises to the serial stream, declares lock, then counts bit errors and detects loss of sync.
- Sits at the far end of the serial test link.
- Provides pass/fail status and a saturating error count for the top-level status outputs.

Parameters:
- LOCK_COUNT, 16: consecutive matching valid bits in HUNT required to enter LOCKED (range 8..255).
- LOSS_THRESH, 4: mismatches in LOCKED, without an intervening clean run, that force a return to HUNT (range 1..15).
- CLEAN_RUN, 8: consecutive matching bits in LOCKED that clear the loss counter (range 1..255).
- ERR_W, 16: width of err_count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  din is valid this cycle; all state advances only when en=1.
- din  in  1  received serial PRBS bit.
- clr_cnt  in  1  synchronous clear of err_count.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse on a counted mismatch.
- err_count  out  ERR_W  saturating count of mismatches seen in LOCKED.
- state_o  out  2  encoded state: 0=HUNT, 1=LOCKED, 2=LOST.

Behaviour:
- Reset values:
  - sr = 7'h7F (matches the generator seed).
  - state = HUNT.
  - locked = 0, err_pulse = 0, err_count = 0.
  - run counter = 0, loss counter = 0.
- Prediction: pred = sr[6] ^ sr[5]; match = (din == pred). Only evaluated when en=1.
- HUNT:
  - sr <= {sr[5:0], din} (self-synchronising; loads the received bit).
  - On match with sr != 0: run++. On mismatch, or sr == 0: run <= 0.
  - The all-zero guard is required: the all-zero pattern matches itself forever but is illegal PRBS.
  - When run reaches LOCK_COUNT: go to LOCKED on the same edge; clear run and loss.
  - No errors are counted in HUNT.
- LOCKED:
  - sr <= {sr[5:0], pred} (free-running reference; din is not fed back).
  - Mismatch:
    - err_pulse=1 in the next cycle.
    - err_count++ (saturates at all-ones).
    - loss++; run <= 0.
  - Match: run++; when run reaches CLEAN_RUN, set loss <= 0 and run <= 0.
  - When loss reaches LOSS_THRESH (on the edge of the mismatch making it so): go to LOST.
- LOST:
  - Held exactly one valid cycle.
  - Clears run and loss, then goes to HUNT. Loads din into sr as in HUNT.
  - That bit is not counted as an error.
- locked is registered and equals (state == LOCKED); it falls on the same edge as the LOCKED->LOST transition.
- err_pulse is registered and lasts exactly one clock, including when en drops the next cycle.
- en=0: all state, counters and sr hold; err_pulse=0.
- clr_cnt:
  - Sets err_count to 0 on the next edge.
  - If clr_cnt coincides with a counted mismatch, the result is 1 (clear, then count this error).
  - Has no effect on state, sr or other counters.
- Saturation: err_count at 2^ERR_W-1 stays there; err_pulse still fires.
- Async rst mid-stream: returns immediately to reset values regardless of en. After deassertion, relock needs at least LOCK_COUNT valid bits.
- Latency: din to err_pulse/err_count update is 1 clock. HUNT to LOCKED takes LOCK_COUNT valid matching bits after sr holds 7 received bits.

Decomposition:
- Shared package prbs_pkg holds:
  - PRBS7 taps (6,5);
  - seed 7'h7F;
  - state encoding (HUNT=0, LOCKED=1, LOST=2);
  - lfsr_next function used by both this checker and the generator.
- One natural sub-module, sat_counter: a parameterised saturating counter with sync clear and increment, used for err_count.

Test Plan:
1. Generator from seed 7'h7F, en=1 continuously → locked rises after LOCK_COUNT matching bits; 500 further bits give err_count=0 and no err_pulse.
2. While locked, invert bit 100 → exactly one err_pulse, err_count=1, locked stays 1; after 8 clean bits the loss counter is 0.
3. While locked, invert 4 bits spaced 2 apart → err_count=4, LOST for one valid cycle, then HUNT, locked=0. Clean stream resumes → relock after 16 bits.
4. din held at 0 for 200 cycles from reset → never locks (all-zero guard); err_count=0.
5. Toggle en 1/0 each cycle with a valid stream → lock and error behaviour identical to scenario 2 in valid-bit terms; everything holds during en=0 cycles.
6. Preload err_count to 0xFFFF via 65535 injected errors (with slow relock) then one more error → stays 0xFFFF with err_pulse. clr_cnt together with an error → count 1. rst asserted mid-LOCKED → all outputs at reset values immediately.
